// File: rtl/counter_stream_checker_pkg.sv
// Shared definitions for the counter and its stream checker: FSM encoding and
// the default word width / step both ends must agree on.
package counter_check_pkg;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        LOCKED = 2'd1,
        SLIP   = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_STEP     = 1;
    localparam int DEF_RESYNC_N = 4;
    localparam int DEF_ERRW     = 8;

endpackage

// File: rtl/counter_stream_checker_sat_counter.sv
// Up-counter with synchronous clear; optionally holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W        = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !(SATURATE && (&count))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/counter_stream_checker.sv
// Checks that each accepted sample equals the previous one plus STEP (mod 2^WIDTH),
// tracking lock state, mismatch pulses and a saturating error count.
module counter_stream_checker
    import counter_check_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STEP     = DEF_STEP,
    parameter int RESYNC_N = DEF_RESYNC_N,
    parameter int ERRW     = DEF_ERRW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             clr_stats,
    output logic             locked,
    output logic             mismatch,
    output logic             sticky_err,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] expected,
    output state_t           dbg_state
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam int               MCW    = 4;

    // Handshake: cnt_valid qualifies cnt_in for exactly one cycle and there is
    // no back-pressure; every cycle with en && cnt_valid consumes one sample.
    state_t           state, state_next;
    logic             accept;
    logic             hit;
    logic             miss_evt;
    logic             run_done;
    logic [MCW-1:0]   match_cnt;
    logic             match_clr;
    logic             match_inc;

    assign accept    = en && cnt_valid;
    assign hit       = (cnt_in == expected);
    assign miss_evt  = accept && (state != SEEK) && !hit;
    assign run_done  = (match_cnt == MCW'(RESYNC_N - 1));
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        case (state)
            SEEK:    if (accept) state_next = LOCKED;
            LOCKED:  if (miss_evt) state_next = SLIP;
            SLIP:    if (accept && hit && run_done) state_next = LOCKED;
            default: state_next = SEEK;
        endcase
    end

    // Every accepted sample (seed, match or reseed) sets the next expectation the same way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEEK;
            locked     <= 1'b0;
            mismatch   <= 1'b0;
            sticky_err <= 1'b0;
            expected   <= '0;
        end else begin
            state    <= state_next;
            locked   <= (state_next == LOCKED);
            mismatch <= miss_evt;
            if (clr_stats) begin
                sticky_err <= 1'b0;
            end else if (miss_evt) begin
                sticky_err <= 1'b1;
            end
            if (accept) begin
                expected <= cnt_in + STEP_W;
            end
        end
    end

    assign match_clr = accept && (((state != SEEK) && !hit) ||
                                  ((state == SLIP) && hit && run_done));
    assign match_inc = accept && (state == SLIP) && hit && !run_done;

    sat_counter #(
        .W        (MCW),
        .SATURATE (1'b0)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (match_clr),
        .inc   (match_inc),
        .count (match_cnt)
    );

    sat_counter #(
        .W        (ERRW),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (miss_evt),
        .count (err_count)
    );

endmodule
